football_kick_ctrl: RTL and testbench
=====================================

FOOTBALL_KICK_CTRL -- requirements
Module: football_kick_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 3: consecutive cycles of decision=1 needed to fire a kick; legal range 2..15.
REQ-002 Parameter KICK_CYCLES, default 4: width of the kick pulse in cycles; legal range 1..15.
REQ-003 Parameter COOL_CYCLES, default 8: cooldown cycles after a kick; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  arms the controller; low blocks new kicks.
REQ-007 sensor  input  3  robot sensor bits {x2,x1,x0}.
REQ-008 decision  output  1  registered decision function of the sampled sensor.
REQ-009 kick  output  1  kick actuator drive.
REQ-010 busy  output  1  high in KICK or COOLDOWN.
REQ-011 state  output  2  current FSM state code.
REQ-012 kick_count  output  8  number of kicks fired, saturating.

Function
REQ-013 sensor SHALL be registered into s_q every cycle, giving 1 cycle of latency.
REQ-014 decision SHALL be f(s_q), where f=1 for s_q in {010,101,110,111} and f=0 for {000,001,011,100}.
REQ-015 The decision SHALL be a combinational function of s_q, so it updates in the same cycle s_q updates.
REQ-016 State codes: IDLE=0, DEBOUNCE=1, KICK=2, COOLDOWN=3.
REQ-017 The encoding SHALL not change; state SHALL drive the current state code directly.
REQ-018 IDLE: when enable=1 and decision=1, the FSM SHALL go to DEBOUNCE and load deb_cnt=1.
REQ-019 IDLE: otherwise the FSM SHALL stay in IDLE.
REQ-020 DEBOUNCE: if enable=0 or decision=0, the FSM SHALL go to IDLE and clear deb_cnt.
REQ-021 DEBOUNCE: if deb_cnt==DEB_CYCLES-1 and decision=1, the FSM SHALL go to KICK.
REQ-022 DEBOUNCE: otherwise deb_cnt SHALL increment and the FSM SHALL stay.
REQ-023 On entry to KICK, the FSM SHALL load kick_cnt=0.
REQ-024 On entry to KICK, kick_count SHALL increment by 1 and hold at 255 with no wrap.
REQ-025 KICK: kick SHALL be 1 for exactly KICK_CYCLES cycles, then the FSM SHALL go to COOLDOWN with cool_cnt=0.
REQ-026 KICK and COOLDOWN: the FSM SHALL ignore sensor and enable; an enable drop mid-kick SHALL not shorten the pulse.
REQ-027 COOLDOWN: the FSM SHALL stay for exactly COOL_CYCLES cycles, then go to IDLE.
REQ-028 COOLDOWN: a decision=1 in the first IDLE cycle SHALL start a new DEBOUNCE, with no gap cycle required.
REQ-029 kick SHALL be a registered output, high exactly when state==KICK.
REQ-030 busy SHALL be high exactly when state is KICK or COOLDOWN.
REQ-031 Latency: with sensor held at a firing value from before edge k, kick SHALL rise after edge k+DEB_CYCLES.
REQ-032 For the REQ-031 case with enable=1 throughout, kick SHALL rise after edge k+3 at defaults.
REQ-033 A single-cycle decision=0 glitch during DEBOUNCE SHALL restart debouncing from IDLE.
REQ-034 Counters SHALL be wide enough for the parameter maxima, with no overflow at legal parameter values.

Reset
REQ-035 rst_n=0 SHALL immediately, without a clock, force state=IDLE.
REQ-036 rst_n=0 SHALL immediately clear s_q=000, decision=0, kick=0, busy=0 and kick_count=0.
REQ-037 rst_n=0 SHALL immediately clear deb_cnt, kick_cnt and cool_cnt.
REQ-038 Reset asserted mid-KICK SHALL drop kick in the same cycle.
REQ-039 After reset, no kick SHALL occur before a fresh debounce.
REQ-040 The first edge after rst_n rises SHALL only sample sensor, with no state transition from stale data.

Verification
REQ-041 Truth table: hold enable=0 and sweep sensor 000..111, 20 cycles each -> decision=0,0,1,0,0,1,1,1; kick stays 0.
REQ-042 Nominal kick: enable=1, sensor=110 held from cycle 0 -> state 0,1,1,2; kick high cycles 4..7; busy cycles 4..15; IDLE at cycle 16; kick_count=1.
REQ-043 Glitch: sensor=101 for 2 cycles, then 011 for 1 cycle, then 101 held -> no kick until 3 further clean cycles; kick_count=1.
REQ-044 Enable drop: drop enable during DEBOUNCE -> IDLE, no kick.
REQ-045 Enable drop: drop enable during KICK -> pulse still lasts 4 cycles.
REQ-046 Reset mid-KICK: assert rst_n=0 asynchronously between edges -> kick=0, state=0 and kick_count=0 at once; no kick within 3 cycles after release.
REQ-047 Saturation: sensor=111 held with enable=1 for 300 kicks -> kick_count reaches 255 and stays 255; the kick pulse continues each cycle.

Source files
------------

// File: rtl/football_kick_ctrl.sv
// Kick controller: registers the robot sensor, decodes a fire decision,
// debounces it, then drives a fixed-width kick pulse followed by a cooldown.
module football_kick_ctrl #(
  parameter int DEB_CYCLES  = 3,
  parameter int KICK_CYCLES = 4,
  parameter int COOL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] sensor,
  output logic       decision,
  output logic       kick,
  output logic       busy,
  output logic [1:0] state,
  output logic [7:0] kick_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    KICK     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] KICK_LAST = 4'(KICK_CYCLES - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOL_CYCLES - 1);

  state_t     cur, nxt;
  logic [2:0] s_q;
  logic [3:0] deb_cnt, deb_nxt;
  logic [3:0] kick_cnt, kick_nxt;
  logic [7:0] cool_cnt, cool_nxt;

  always_comb begin
    case (s_q)
      3'b010, 3'b101, 3'b110, 3'b111: decision = 1'b1;
      default:                        decision = 1'b0;
    endcase
  end

  always_comb begin
    nxt      = cur;
    deb_nxt  = deb_cnt;
    kick_nxt = kick_cnt;
    cool_nxt = cool_cnt;
    case (cur)
      IDLE: begin
        if (enable && decision) begin
          nxt     = DEBOUNCE;
          deb_nxt = 4'd1;
        end
      end
      DEBOUNCE: begin
        if (!enable || !decision) begin
          nxt     = IDLE;
          deb_nxt = 4'd0;
        end else if (deb_cnt == DEB_LAST) begin
          nxt      = KICK;
          deb_nxt  = 4'd0;
          kick_nxt = 4'd0;
        end else begin
          deb_nxt = deb_cnt + 4'd1;
        end
      end
      // sensor and enable are deliberately ignored once the kick is committed
      KICK: begin
        if (kick_cnt == KICK_LAST) begin
          nxt      = COOLDOWN;
          cool_nxt = 8'd0;
        end else begin
          kick_nxt = kick_cnt + 4'd1;
        end
      end
      COOLDOWN: begin
        if (cool_cnt == COOL_LAST) nxt = IDLE;
        else                       cool_nxt = cool_cnt + 8'd1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= IDLE;
      s_q        <= 3'b000;
      deb_cnt    <= 4'd0;
      kick_cnt   <= 4'd0;
      cool_cnt   <= 8'd0;
      kick       <= 1'b0;
      busy       <= 1'b0;
      kick_count <= 8'd0;
    end else begin
      cur      <= nxt;
      s_q      <= sensor;
      deb_cnt  <= deb_nxt;
      kick_cnt <= kick_nxt;
      cool_cnt <= cool_nxt;
      // outputs registered from next state so they track state exactly
      kick     <= (nxt == KICK);
      busy     <= (nxt == KICK) || (nxt == COOLDOWN);
      if (cur == DEBOUNCE && nxt == KICK && kick_count != 8'hFF)
        kick_count <= kick_count + 8'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_football_kick_ctrl.sv
// Scoreboard bench for football_kick_ctrl: a phase-timer reference model
// pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_football_kick_ctrl;
  localparam int DEB  = 3;
  localparam int KCK  = 4;
  localparam int COOL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] sensor = 3'b000;
  logic       decision, kick, busy;
  logic [1:0] state;
  logic [7:0] kick_count;

  int checks = 0;
  int errors = 0;

  // expected = {decision, kick, busy, state, kick_count}
  logic [12:0] exp_q[$];

  // reference model: remaining busy time and current qualifying streak
  logic [7:0] dec_tab = 8'b1110_0100;
  logic [2:0] m_sq;
  int         m_streak, m_left, m_count;

  football_kick_ctrl #(.DEB_CYCLES(DEB), .KICK_CYCLES(KCK), .COOL_CYCLES(COOL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor(sensor),
    .decision(decision), .kick(kick), .busy(busy), .state(state),
    .kick_count(kick_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_sq = 3'b000; m_streak = 0; m_left = 0; m_count = 0;
  endfunction

  function automatic logic [12:0] model_out();
    logic [1:0] st;
    logic       d;
    if (m_left > COOL)  st = 2'd2;
    else if (m_left > 0) st = 2'd3;
    else if (m_streak > 0) st = 2'd1;
    else st = 2'd0;
    d = dec_tab[m_sq];
    return {d, st == 2'd2, m_left > 0, st, 8'(m_count)};
  endfunction

  function automatic void model_edge(input logic [2:0] s, input logic e);
    logic d;
    d = dec_tab[m_sq];
    if (m_left > 0) begin
      m_left--;
    end else if (e && d) begin
      m_streak++;
      if (m_streak == DEB) begin
        m_streak = 0;
        m_left   = KCK + COOL;
        if (m_count < 255) m_count++;
      end
    end else begin
      m_streak = 0;
    end
    m_sq = s;
  endfunction

  task automatic tick(input logic [2:0] s, input logic e);
    sensor = s; enable = e;
    @(posedge clk); #1;
    model_edge(s, e);
    exp_q.push_back(model_out());
  endtask

  task automatic check_now(input string name, input logic [12:0] want);
    logic [12:0] got;
    got = {decision, kick, busy, state, kick_count};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // async reset between edges, checked immediately without a clock
  task automatic do_reset(input logic [2:0] s_hold);
    @(negedge clk); #1;
    sensor = s_hold; enable = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_now("async_reset", 13'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [12:0] want, got;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {decision, kick, busy, state, kick_count};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle_out t=%0t got=%h want=%h", $time, got, want);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    rst_n = 1'b0;
    #12;
    check_now("por_reset", 13'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // truth table with enable low
    for (int v = 0; v < 8; v++)
      for (int c = 0; c < 20; c++) tick(3'(v), 1'b0);

    // nominal kick
    do_reset(3'b110);
    for (int c = 0; c < 22; c++) tick(3'b110, 1'b1);

    // glitch during debounce
    do_reset(3'b000);
    tick(3'b000, 1'b1);
    tick(3'b101, 1'b1); tick(3'b101, 1'b1); tick(3'b011, 1'b1);
    for (int c = 0; c < 20; c++) tick(3'b101, 1'b1);

    // enable drop during debounce
    do_reset(3'b000);
    tick(3'b110, 1'b1); tick(3'b110, 1'b1); tick(3'b110, 1'b1);
    for (int c = 0; c < 6; c++) tick(3'b110, 1'b0);

    // enable drop during kick
    do_reset(3'b000);
    for (int c = 0; c < 6; c++) tick(3'b110, 1'b1);
    for (int c = 0; c < 16; c++) tick(3'b110, 1'b0);

    // reset mid-kick, firing sensor held across release
    do_reset(3'b000);
    for (int c = 0; c < 6; c++) tick(3'b110, 1'b1);
    do_reset(3'b110);
    for (int c = 0; c < 8; c++) tick(3'b110, 1'b1);

    // randomized traffic
    for (int c = 0; c < 600; c++)
      tick(3'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0));

    // saturation: back-to-back kicks well past 255
    do_reset(3'b111);
    for (int c = 0; c < 300 * (1 + (DEB - 1) + KCK + COOL) + 20; c++) tick(3'b111, 1'b1);
    check_now("sat_count", {1'b1, kick, busy, state, 8'd255});

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk); guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
